// File: rtl/sub_rr_scheduler_pkg.sv
// sub_sched_pkg: shared state encoding and default sizing for the round-robin subtract scheduler.
package sub_sched_pkg;
    localparam int DEF_N    = 16;
    localparam int DEF_NREQ = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/sub_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; grants the first set request at or after ptr, wrapping.
module rr_pick
    import sub_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    always_comb begin
        int j;
        idx = '0;
        // Scan farthest-first so the candidate nearest ptr is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) idx = IDW'(j);
        end
        grant = (|req) ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/sub_rr_scheduler.sv
// sub_rr_scheduler: shares one ripple-borrow subtractor among NREQ requesters with
// round-robin arbitration and a single valid/ready response channel.
module sub_rr_scheduler
    import sub_sched_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] input1,
    input  logic [NREQ*N-1:0] input2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      answer,
    output logic              borrow,
    output logic              busy
);
    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, rsp_id_q, rsp_id_d, pick_idx;
    logic [N-1:0]    a_q, a_d, b_q, b_d, answer_q, answer_d, diff;
    logic            borrow_q, borrow_d, bout;
    logic [NREQ-1:0] pick_grant;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        logic c;
        c    = 1'b0;
        diff = '0;
        for (int i = 0; i < N; i++) begin
            diff[i] = a_q[i] ^ b_q[i] ^ c;
            c       = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
        end
        bout = c;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        a_d      = a_q;
        b_d      = b_q;
        answer_d = answer_q;
        borrow_d = borrow_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            S_IDLE: if (|req_valid) begin
                state_d = S_EXEC;
                gidx_d  = pick_idx;
                a_d     = input1[int'(pick_idx) * N +: N];
                b_d     = input2[int'(pick_idx) * N +: N];
            end
            S_EXEC: begin
                state_d  = S_RESP;
                answer_d = diff;
                borrow_d = bout;
                rsp_id_d = gidx_q;
            end
            S_RESP: if (rsp_ready) begin
                state_d  = S_IDLE;
                rr_ptr_d = (gidx_q == IDW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            answer_q <= '0;
            borrow_q <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            answer_q <= answer_d;
            borrow_q <= borrow_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) ? pick_grant : '0;
    assign rsp_valid = state_q == S_RESP;
    assign busy      = state_q != S_IDLE;
    assign answer    = answer_q;
    assign borrow    = borrow_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_sub_rr_scheduler.sv
// tb_sub_rr_scheduler: directed scenario tasks for the round-robin subtract scheduler.
module tb_sub_rr_scheduler;
    localparam int N = 16, NREQ = 4, IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] input1 = '0, input2 = '0;
    logic              rsp_valid, borrow, busy;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      answer;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sub_rr_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .input1    (input1),
        .input2    (input2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .answer    (answer),
        .borrow    (borrow),
        .busy      (busy)
    );

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        input1[i*N +: N] = a;
        input2[i*N +: N] = b;
    endtask

    // Called just after a falling edge; returns once a grant is visible or the budget runs out.
    task automatic wait_grant(output bit ok);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = req_ready != '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_id, answer, borrow, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_ready, rsp_valid, rsp_id, answer, borrow, busy});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        set_op(2, 16'd5432, 16'd1234);
        req_valid = 4'b0100;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_exec: ready=%b valid=%b busy=%b expected 0000/0/1", req_ready, rsp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || answer !== 16'd4198 || borrow !== 1'b0 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_rsp: v=%b ans=%0d b=%b id=%0d expected 1/4198/0/2", rsp_valid, answer, borrow, rsp_id);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b valid=%b expected 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_underflow();
        logic [N-1:0] a [3] = '{16'd1234, 16'd0, 16'h8000};
        logic [N-1:0] b [3] = '{16'd5432, 16'd1, 16'h8000};
        logic [N-1:0] ea[3] = '{16'hEF9A, 16'hFFFF, 16'h0000};
        logic         eb[3] = '{1'b1, 1'b1, 1'b0};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            set_op(0, a[k], b[k]);
            req_valid = 4'b0001;
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL uflow_grant[%0d]: got %b expected 0001", k, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || answer !== ea[k] || borrow !== eb[k] || rsp_id !== 2'd0) begin
                errors++;
                $display("FAIL uflow_rsp[%0d]: v=%b ans=%h b=%b id=%0d expected 1/%h/%b/0",
                         k, rsp_valid, answer, borrow, rsp_id, ea[k], eb[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] ea[4] = '{16'd70, 16'd65436, 16'd0, 16'd6999};
        logic         eb[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit ok;
        int e;
        rst_n = 1'b0;
        set_op(0, 16'd100, 16'd30);
        set_op(1, 16'd300, 16'd400);
        set_op(2, 16'd50, 16'd50);
        set_op(3, 16'd7000, 16'd1);
        req_valid = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== 4'(1 << e)) begin
                errors++;
                $display("FAIL cont_grant[%0d]: got %b expected one-hot %0d", k, req_ready, e);
            end
            @(negedge clk);
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL cont_exec_ready[%0d]: got %b expected 0000", k, req_ready);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e) || answer !== ea[e] || borrow !== eb[e]) begin
                errors++;
                $display("FAIL cont_rsp[%0d]: v=%b id=%0d ans=%0d b=%b expected 1/%0d/%0d/%b",
                         k, rsp_valid, rsp_id, answer, borrow, e, ea[e], eb[e]);
            end
            if (k == 4) req_valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_ready = 1'b0;
        set_op(1, 16'd3000, 16'd1000);
        req_valid = 4'b0010;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        set_op(3, 16'd9, 16'd8);
        req_valid = 4'b1000;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || answer !== 16'd2000 || borrow !== 1'b0 || rsp_id !== 2'd1 ||
                req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b ans=%0d b=%b id=%0d rdy=%b busy=%b expected 1/2000/0/1/0000/1",
                         i, rsp_valid, answer, borrow, rsp_id, req_ready, busy);
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || answer !== 16'd2000) begin
            errors++;
            $display("FAIL bp_sixth: v=%b ans=%0d expected 1/2000", rsp_valid, answer);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b valid=%b expected 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_operand_change();
        bit ok;
        set_op(1, 16'd900, 16'd100);
        req_valid = 4'b0010;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL opchg_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        set_op(1, 16'd5, 16'd10);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || answer !== 16'd800 || borrow !== 1'b0 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL opchg_rsp: v=%b ans=%0d b=%b id=%0d expected 1/800/0/1", rsp_valid, answer, borrow, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        set_op(2, 16'd700, 16'd200);
        req_valid = 4'b0100;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rst_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, answer, borrow, busy} !== '0) begin
            errors++;
            $display("FAIL rst_async: got %h expected 0", {req_ready, rsp_valid, rsp_id, answer, borrow, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_rsp[%0d]: valid=%b busy=%b expected 0/0", i, rsp_valid, busy);
            end
        end
        set_op(1, 16'd50, 16'd20);
        set_op(3, 16'd40, 16'd45);
        req_valid = 4'b1010;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rst_ptr_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || answer !== 16'd30 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_rsp1: v=%b ans=%0d id=%0d expected 1/30/1", rsp_valid, answer, rsp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rst_grant3: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || answer !== 16'd65531 || borrow !== 1'b1 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL rst_rsp3: v=%b ans=%0d b=%b id=%0d expected 1/65531/1/3", rsp_valid, answer, borrow, rsp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_underflow();
        test_contention();
        test_backpressure();
        test_operand_change();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
